// File: rtl/path_sequencer.sv
// path_sequencer: buffers a CPU node path, streams it into the mapper, then sequences node and turn events
module path_sequencer #(
    parameter int MAX_LEN  = 25,
    parameter int NODE_GAP = 3125,
    parameter int TURN_LAT = 8
) (
    input  logic       clk_3125KHz,
    input  logic       rst_n,
    input  logic       cpu_valid,
    input  logic [4:0] cpu_node,
    input  logic       cpu_last,
    output logic       cpu_ready,
    input  logic       node_flag,
    input  logic [1:0] turn_flag,
    output logic       path_input,
    output logic [4:0] path_planned,
    output logic       node_changed,
    output logic [1:0] turn_cmd,
    output logic       turn_valid,
    output logic       path_done,
    output logic [4:0] path_len,
    output logic [4:0] nodes_passed,
    output logic       err_overflow
);
    localparam int GW = (NODE_GAP > 1) ? $clog2(NODE_GAP) : 1;
    localparam int TW = $clog2(TURN_LAT + 1);
    localparam logic [4:0]    MAXL = 5'(MAX_LEN);
    localparam logic [GW-1:0] GAPL = GW'(NODE_GAP - 1);
    localparam logic [TW-1:0] LATL = TW'(TURN_LAT);

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, PRIME, RUN, TURN, DONE} state_t;

    state_t        state_q, state_d;
    logic [4:0]    len_q, len_d, np_q, np_d, idx_q, idx_d, wr_len;
    logic          err_q, err_d, nc_q, nc_d, tv_q, tv_d, rdy_q;
    logic [1:0]    cmd_q, cmd_d;
    logic [TW-1:0] lat_q, lat_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [2:0]    sync_q;
    logic [4:0]    mem_q [MAX_LEN];
    logic          hs, rise, wr_en;

    assign hs     = cpu_valid && cpu_ready;
    assign rise   = sync_q[1] && !sync_q[2];
    assign wr_len = (state_q == LOAD) ? len_q : 5'd0;

    assign cpu_ready    = rdy_q && (state_q == IDLE || state_q == LOAD || state_q == DONE);
    assign path_input   = state_q == STREAM;
    assign path_planned = path_input ? mem_q[idx_q] : 5'd0;
    assign node_changed = nc_q;
    assign turn_cmd     = cmd_q;
    assign turn_valid   = tv_q;
    assign path_done    = state_q == DONE;
    assign path_len     = len_q;
    assign nodes_passed = np_q;
    assign err_overflow = err_q;

    // Path buffer holds no reset; only indices below path_len are ever read
    always_ff @(posedge clk_3125KHz) begin
        if (wr_en) mem_q[wr_len] <= cpu_node;
    end

    // State, counters, output registers and the node_flag synchronizer/edge history
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            np_q    <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            nc_q    <= 1'b0;
            tv_q    <= 1'b0;
            rdy_q   <= 1'b0;
            cmd_q   <= '0;
            lat_q   <= '0;
            gap_q   <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            np_q    <= np_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            nc_q    <= nc_d;
            tv_q    <= tv_d;
            rdy_q   <= 1'b1;
            cmd_q   <= cmd_d;
            lat_q   <= lat_d;
            gap_q   <= gap_d;
            sync_q  <= {sync_q[1:0], node_flag};
        end
    end

    // Next-state logic; lat_q restarts on every node_changed so turn_valid lands TURN_LAT+1 cycles later
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        np_d    = np_q;
        idx_d   = idx_q;
        err_d   = err_q;
        cmd_d   = cmd_q;
        lat_d   = lat_q;
        gap_d   = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
        nc_d    = 1'b0;
        tv_d    = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE, LOAD, DONE: begin
                if (hs) begin
                    if (state_q != LOAD) begin
                        np_d  = '0;
                        err_d = 1'b0;
                    end
                    if (wr_len < MAXL) begin
                        wr_en = 1'b1;
                        len_d = wr_len + 5'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                    idx_d   = '0;
                    state_d = !cpu_last ? LOAD : (len_d >= 5'd2 ? STREAM : DONE);
                end
            end
            STREAM: begin
                idx_d = idx_q + 5'd1;
                if (idx_q == len_q - 5'd1) begin
                    state_d = PRIME;
                    nc_d    = 1'b1;
                    lat_d   = '0;
                end
            end
            PRIME: begin
                lat_d   = lat_q + TW'(1);
                state_d = TURN;
            end
            RUN: begin
                if (rise && gap_q == '0) begin
                    gap_d = GAPL;
                    np_d  = np_q + 5'd1;
                    if (np_d == len_q - 5'd1) begin
                        state_d = DONE;
                    end else begin
                        nc_d    = 1'b1;
                        lat_d   = '0;
                        state_d = TURN;
                    end
                end
            end
            TURN: begin
                lat_d = lat_q + TW'(1);
                if (lat_q == LATL) begin
                    cmd_d   = turn_flag;
                    tv_d    = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_path_sequencer.sv
// tb_path_sequencer: randomized path loads and node events checked against a path-level reference model
module tb_path_sequencer;
    localparam int MAX_LEN  = 25;
    localparam int NODE_GAP = 3125;
    localparam int TURN_LAT = 8;

    typedef logic [4:0] node_q_t[$];

    logic       clk_3125KHz = 1'b0;
    logic       rst_n = 1'b1;
    logic       cpu_valid = 1'b0, cpu_last = 1'b0, node_flag = 1'b0;
    logic [4:0] cpu_node = '0;
    logic [1:0] turn_flag = '0;
    logic       cpu_ready, path_input, node_changed, turn_valid, path_done, err_overflow;
    logic [4:0] path_planned, path_len, nodes_passed;
    logic [1:0] turn_cmd;
    logic [22:0] outs;

    int n_chk = 0, n_err = 0, cyc = 0;
    int nc_cyc[$], tv_cyc[$];
    logic [4:0] got_stream[$], exp_stream[$];
    logic [1:0] tv_cmd[$], exp_cmd[$];
    int first_pi = -1, both = 0, hs_cyc = 0;
    int m_len = 0, m_np = 0, m_nc = 0, r_last = -100000;
    bit m_done = 1'b0, m_err = 1'b0;

    path_sequencer #(.MAX_LEN(MAX_LEN), .NODE_GAP(NODE_GAP), .TURN_LAT(TURN_LAT)) dut (
        .clk_3125KHz (clk_3125KHz),
        .rst_n       (rst_n),
        .cpu_valid   (cpu_valid),
        .cpu_node    (cpu_node),
        .cpu_last    (cpu_last),
        .cpu_ready   (cpu_ready),
        .node_flag   (node_flag),
        .turn_flag   (turn_flag),
        .path_input  (path_input),
        .path_planned(path_planned),
        .node_changed(node_changed),
        .turn_cmd    (turn_cmd),
        .turn_valid  (turn_valid),
        .path_done   (path_done),
        .path_len    (path_len),
        .nodes_passed(nodes_passed),
        .err_overflow(err_overflow)
    );

    assign outs = {cpu_ready, path_input, path_planned, node_changed, turn_cmd, turn_valid,
                   path_done, path_len, nodes_passed, err_overflow};

    always #5 clk_3125KHz = ~clk_3125KHz;
    always @(posedge clk_3125KHz) cyc <= cyc + 1;

    // Observe the mapper-facing outputs; present a fresh random turn code after each node_changed
    always @(negedge clk_3125KHz) begin
        if (path_input) begin
            got_stream.push_back(path_planned);
            if (first_pi < 0) first_pi = cyc;
        end
        if (node_changed) begin
            nc_cyc.push_back(cyc);
            both += int'(path_input);
            turn_flag = 2'($urandom);
            exp_cmd.push_back(turn_flag);
        end
        if (turn_valid) begin
            tv_cyc.push_back(cyc);
            tv_cmd.push_back(turn_cmd);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic node_q_t rand_path(input int n);
        node_q_t q;
        for (int i = 0; i < n; i++) q.push_back(5'($urandom));
        return q;
    endfunction

    task automatic send_path(input node_q_t nodes);
        int w;
        nc_cyc.delete(); tv_cyc.delete(); got_stream.delete();
        tv_cmd.delete(); exp_cmd.delete(); exp_stream.delete();
        first_pi = -1; both = 0;
        m_len = 0; m_np = 0; m_err = 1'b0; m_done = 1'b0;
        foreach (nodes[i]) begin
            @(negedge clk_3125KHz);
            if (i == 1) check("done_fall", path_done, 0);
            w = 0;
            while (!cpu_ready && w < 10) begin
                @(negedge clk_3125KHz);
                w++;
            end
            if (!cpu_ready) check("ready_timeout", cpu_ready, 1);
            cpu_valid = 1'b1;
            cpu_node  = nodes[i];
            cpu_last  = (i == nodes.size() - 1);
            if (m_len < MAX_LEN) begin
                exp_stream.push_back(nodes[i]);
                m_len++;
            end else begin
                m_err = 1'b1;
            end
        end
        @(negedge clk_3125KHz);
        hs_cyc = cyc;
        cpu_valid = 1'b0;
        cpu_last  = 1'b0;
        m_done = m_len < 2;
        m_nc   = (m_len >= 2) ? 1 : 0;
    endtask

    task automatic verify_load();
        int ns;
        ns = (m_len >= 2) ? m_len : 0;
        repeat (m_len + TURN_LAT + 8) @(negedge clk_3125KHz);
        check("path_len", path_len, m_len);
        check("err_overflow", err_overflow, m_err);
        check("load_nodes_passed", nodes_passed, m_np);
        check("stream_len", got_stream.size(), ns);
        for (int i = 0; i < ns && i < got_stream.size(); i++)
            check($sformatf("stream[%0d]", i), got_stream[i], exp_stream[i]);
        check("load_path_done", path_done, m_done);
        check("load_nc_count", nc_cyc.size(), m_nc);
        check("pi_nc_overlap", both, 0);
        if (ns > 0) begin
            check("stream_start", first_pi, hs_cyc);
            check("prime_tv_count", tv_cyc.size(), 1);
            if (nc_cyc.size() > 0) begin
                check("prime_cycle", nc_cyc[0], hs_cyc + m_len);
                if (tv_cyc.size() > 0) check("prime_turn_lat", tv_cyc[0], nc_cyc[0] + TURN_LAT + 1);
            end
            if (tv_cmd.size() > 0 && exp_cmd.size() > 0) check("prime_turn_cmd", tv_cmd[0], exp_cmd[0]);
        end
    endtask

    task automatic node_event(input int gap);
        bit acc;
        int r;
        while (cyc < r_last + gap) @(negedge clk_3125KHz);
        r = cyc;
        node_flag = 1'b1;
        acc = m_len >= 2 && !m_done && r - r_last >= NODE_GAP;
        if (acc) begin
            r_last = r;
            m_np++;
            if (m_np == m_len - 1) m_done = 1'b1;
            else m_nc++;
        end
        repeat (4) @(negedge clk_3125KHz);
        node_flag = 1'b0;
        repeat (TURN_LAT + 8) @(negedge clk_3125KHz);
        check("nodes_passed", nodes_passed, m_np);
        check("path_done", path_done, m_done);
        check("nc_count", nc_cyc.size(), m_nc);
        check("tv_count", tv_cyc.size(), m_nc);
        if (acc && !m_done && nc_cyc.size() > 0) begin
            check("node_latency", nc_cyc[$], r + 3);
            if (tv_cyc.size() > 0) check("turn_lat", tv_cyc[$], nc_cyc[$] + TURN_LAT + 1);
            if (tv_cmd.size() > 0) check("turn_cmd", tv_cmd[$], exp_cmd[$]);
        end
    endtask

    task automatic run_to_done();
        for (int k = 0; k < 30 && !m_done; k++) node_event(3200);
    endtask

    initial begin
        node_q_t p;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk_3125KHz);
        check("reset_outs", outs, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_3125KHz);
        check("ready_after_reset", cpu_ready, 1);

        p = '{5'd0, 5'd1, 5'd2, 5'd8};
        send_path(p);
        verify_load();
        node_event(3200);
        node_event(100);
        node_event(3200);
        node_event(3200);
        check("nominal_nodes_passed", nodes_passed, 3);
        check("nominal_done", path_done, 1);

        p = rand_path(28);
        send_path(p);
        verify_load();
        while (cyc < r_last + 3200) @(negedge clk_3125KHz);
        node_flag = 1'b1;
        repeat (5) @(negedge clk_3125KHz);
        check("pre_reset_err", err_overflow, 1);
        #2 rst_n = 1'b0;
        #1 check("rst_turn_outs", outs, 0);
        node_flag = 1'b0;
        @(negedge clk_3125KHz);
        rst_n = 1'b1;
        r_last = -100000;
        repeat (2) @(negedge clk_3125KHz);
        check("ready_after_turn_reset", cpu_ready, 1);

        p = rand_path(10);
        send_path(p);
        repeat (3) @(negedge clk_3125KHz);
        check("stream_active", path_input, 1);
        #2 rst_n = 1'b0;
        #1 check("rst_stream_drop", path_input, 0);
        check("rst_stream_outs", outs, 0);
        @(negedge clk_3125KHz);
        rst_n = 1'b1;
        r_last = -100000;

        for (int k = 0; k < 2; k++) begin
            p = rand_path(2 + $urandom_range(0, 3));
            send_path(p);
            verify_load();
            run_to_done();
        end

        p = rand_path(1);
        send_path(p);
        verify_load();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
